accum_bank: RTL and testbench
=============================

ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 Parameter WIDTH, default 8, data and register width in bits (2..32).
REQ-002 Parameter NUM_CH, default 4, number of accumulator channels (power of two, 2..16); CW = log2(NUM_CH).
REQ-003 Parameter BIAS, default 5, constant added on every ADD and on the peek path.
REQ-004 Port clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port in_valid  in  1  command present.
REQ-007 Port in_ready  out  1  block accepts a command this cycle.
REQ-008 Port in_ch  in  CW  target channel.
REQ-009 Port in_op  in  2  opcode: 0 LOAD, 1 ADD, 2 SUB, 3 CLEAR_ALL.
REQ-010 Port in_data  in  WIDTH  operand.
REQ-011 Port out_valid  out  1  result present.
REQ-012 Port out_ready  in  1  consumer takes result.
REQ-013 Port out_ch  out  CW  channel of result.
REQ-014 Port out_data  out  WIDTH  post-update channel value.
REQ-015 Port peek_ch  in  CW  channel to observe.
REQ-016 Port peek_data  out  WIDTH  combinational acc[peek_ch] + BIAS, mod 2^WIDTH.
REQ-017 Port overflow  out  1  sticky arithmetic-overflow flag.

Function
REQ-018 Accept = in_valid && in_ready; in_ready = (state == IDLE) && (!out_valid || out_ready).
REQ-019 LOAD: acc[in_ch] <= in_data. ADD: acc[in_ch] <= acc[in_ch] + in_data + BIAS. SUB: acc[in_ch] <= acc[in_ch] - in_data. Result is WIDTH bits wide.
REQ-020 Latency 1: for LOAD/ADD/SUB accepted in cycle N, out_valid = 1 in N+1, out_ch = in_ch, out_data = new acc value.
REQ-021 out_valid holds, with out_ch/out_data stable, until out_valid && out_ready; a new accept in the same cycle as that drain is allowed (full throughput).
REQ-022 Back-to-back commands to the same channel use the updated value with no bubble.
REQ-023 FSM states IDLE, SWEEP. An accepted CLEAR_ALL moves IDLE->SWEEP and zeroes channel 0..NUM_CH-1, one channel per cycle, using an internal CW-bit index.
REQ-024 SWEEP->IDLE after channel NUM_CH-1 is zeroed; out_valid then asserts with out_ch = NUM_CH-1 and out_data = 0; in_ready stays 0 throughout SWEEP.
REQ-025 overflow sets on an ADD carry out of WIDTH bits (operands and BIAS included) or a SUB borrow; it clears only on reset or CLEAR_ALL completion; set wins if both occur in the same cycle.
REQ-026 peek_data reflects register contents only, with no forwarding from the in-flight command.

Reset
REQ-027 On rst_n low, asynchronously: all acc = 0, state = IDLE, sweep index = 0, out_valid = 0, out_ch = 0, out_data = 0, overflow = 0.
REQ-028 Reset during SWEEP or with out_valid high abandons the operation; no result is produced after release.

Configuration
REQ-029 Macro ACCUM_BANK_SAT_EN: when defined, ADD clamps to 2^WIDTH-1 and SUB clamps to 0 on overflow, and overflow still sets; when undefined, arithmetic wraps modulo 2^WIDTH.

Structure
REQ-030 Package accum_bank_pkg holds the opcode enum (OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR_ALL) and the state enum (ST_IDLE, ST_SWEEP).
REQ-031 Sub-module accum_alu (combinational) computes the next value and the overflow bit from op, current value, operand and BIAS, and contains the ACCUM_BANK_SAT_EN logic.

Verification (WIDTH=8, NUM_CH=4, BIAS=5)
REQ-032 LOAD ch2 = 0x10, then ADD ch2 0x03 on the next cycle -> out_data 0x10, then 0x18; peek_ch=2 -> peek_data 0x1D.
REQ-033 LOAD ch1 0xFE, then ADD ch1 0x01 -> wrap build: out_data 0x04, overflow=1; SAT build: out_data 0xFF, overflow=1.
REQ-034 out_ready held 0 for 3 cycles after a result -> out_valid/out_data stable, in_ready=0; out_ready=1 with a queued command -> drain and accept in the same cycle.
REQ-035 CLEAR_ALL with all channels nonzero and overflow=1 -> in_ready low for 4 cycles, then out_valid with out_ch=3, out_data=0; all peeks 0x05; overflow=0.
REQ-036 rst_n pulsed low for half a cycle mid-SWEEP -> all outputs 0 immediately and no out_valid after release.
REQ-037 SUB ch0 0x01 from reset -> wrap build: 0xFF; SAT build: 0x00; overflow=1 in both builds.

Source files
------------

// File: rtl/accum_bank_pkg.sv
// Shared opcode and FSM state types for the accumulator bank.
// The optional saturating mode is selected with ACCUM_BANK_SAT_EN.
package accum_bank_pkg;

  typedef enum logic [1:0] {
    OP_LOAD      = 2'd0,
    OP_ADD       = 2'd1,
    OP_SUB       = 2'd2,
    OP_CLEAR_ALL = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/accum_bank_alu.sv
// Combinational next-value and overflow for one accumulator update.
// ACCUM_BANK_SAT_EN defined: clamp on overflow; undefined: wrap modulo 2^WIDTH.
module accum_alu
  import accum_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BIAS  = 5
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] next_o,
  output logic             ovf_o
);

  localparam logic [WIDTH+1:0] BIAS_X = (WIDTH+2)'(BIAS);

  // Two guard bits hold the carry of cur + operand + BIAS.
  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   diff;

  assign sum  = {2'b00, cur_i} + {2'b00, operand_i} + BIAS_X;
  assign diff = {1'b0, cur_i} - {1'b0, operand_i};

  always_comb begin
    next_o = '0;
    ovf_o  = 1'b0;
    case (op_i)
      OP_LOAD: next_o = operand_i;
      OP_ADD: begin
        next_o = sum[WIDTH-1:0];
        ovf_o  = |sum[WIDTH+1:WIDTH];
`ifdef ACCUM_BANK_SAT_EN
        if (ovf_o) next_o = '1;
`endif
      end
      OP_SUB: begin
        next_o = diff[WIDTH-1:0];
        ovf_o  = diff[WIDTH];
`ifdef ACCUM_BANK_SAT_EN
        if (ovf_o) next_o = '0;
`endif
      end
      OP_CLEAR_ALL: next_o = '0;
    endcase
  end

endmodule

// File: rtl/accum_bank.sv
// Bank of NUM_CH accumulators with a one-deep result register and a CLEAR_ALL sweep.
// Saturating arithmetic is enabled by defining ACCUM_BANK_SAT_EN.
module accum_bank
  import accum_bank_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  parameter  int BIAS   = 5,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_ch,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ch,
  output logic [WIDTH-1:0] out_data,
  input  logic [CW-1:0]    peek_ch,
  output logic [WIDTH-1:0] peek_data,
  output logic             overflow
);

  logic [WIDTH-1:0] acc_q [NUM_CH];
  state_e           state_q;
  logic [CW-1:0]    sweep_idx_q;
  logic             out_valid_q;
  logic [CW-1:0]    out_ch_q;
  logic [WIDTH-1:0] out_data_q;
  logic             overflow_q;

  op_e              op;
  logic             accept;
  logic [WIDTH-1:0] alu_next;
  logic             alu_ovf;
  logic [NUM_CH-1:0] acc_we;
  logic [WIDTH-1:0] acc_wdata;

  assign op       = op_e'(in_op);
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  accum_alu #(
    .WIDTH (WIDTH),
    .BIAS  (BIAS)
  ) u_alu (
    .op_i      (op),
    .cur_i     (acc_q[in_ch]),
    .operand_i (in_data),
    .next_o    (alu_next),
    .ovf_o     (alu_ovf)
  );

  // The sweep and a command never write in the same cycle: in_ready is low in SWEEP.
  assign acc_wdata = (state_q == ST_SWEEP) ? '0 : alu_next;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign acc_we[gi] = (accept && (op != OP_CLEAR_ALL) && (in_ch == CW'(gi))) ||
                        ((state_q == ST_SWEEP) && (sweep_idx_q == CW'(gi)));

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        acc_q[gi] <= '0;
      end else if (acc_we[gi]) begin
        acc_q[gi] <= acc_wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sweep_idx_q <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_CLEAR_ALL) begin
              state_q     <= ST_SWEEP;
              sweep_idx_q <= '0;
            end else begin
              out_valid_q <= 1'b1;
              out_ch_q    <= in_ch;
              out_data_q  <= alu_next;
              if (alu_ovf) overflow_q <= 1'b1;
            end
          end
        end
        ST_SWEEP: begin
          sweep_idx_q <= sweep_idx_q + 1'b1;
          if (sweep_idx_q == CW'(NUM_CH - 1)) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b1;
            out_ch_q    <= sweep_idx_q;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
  assign peek_data = acc_q[peek_ch] + WIDTH'(BIAS);

endmodule

// File: tb/tb_accum_bank.sv
// Directed self-checking bench for accum_bank (WIDTH=8, NUM_CH=4, BIAS=5).
// Expected arithmetic results follow ACCUM_BANK_SAT_EN when it is defined.
module tb_accum_bank;
  import accum_bank_pkg::*;

`ifdef ACCUM_BANK_SAT_EN
  localparam logic [7:0] SUB0_EXP = 8'h00;
  localparam logic [7:0] ADD1_EXP = 8'hFF;
`else
  localparam logic [7:0] SUB0_EXP = 8'hFF;
  localparam logic [7:0] ADD1_EXP = 8'h04;
`endif

  logic       clock;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ch;
  logic [1:0] in_op;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;
  logic [7:0] out_data;
  logic [1:0] peek_ch;
  logic [7:0] peek_data;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  accum_bank #(
    .WIDTH  (8),
    .NUM_CH (4),
    .BIAS   (5)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .peek_ch   (peek_ch),
    .peek_data (peek_data),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input op_e op, input logic [1:0] ch, input logic [7:0] d);
    in_valid = v;
    in_op    = op;
    in_ch    = ch;
    in_data  = d;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_op = '0; in_data = '0;
    out_ready = 1'b1; peek_ch = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_peek0", peek_data, 8'h05);
    #10 rst_n = 1'b1;
    tick();

    // LOAD then ADD on the same channel, back to back
    drive(1'b1, OP_LOAD, 2'd2, 8'h10); tick();
    $display("LOAD ch2 0x10 -> out_ch %0d out_data 0x%0h", out_ch, out_data);
    chk("load_valid", out_valid, 1);
    chk("load_data", out_data, 8'h10);
    chk("load_ch", out_ch, 2);
    drive(1'b1, OP_ADD, 2'd2, 8'h03); tick();
    $display("ADD ch2 0x03 -> out_ch %0d out_data 0x%0h", out_ch, out_data);
    chk("add_valid", out_valid, 1);
    chk("add_data", out_data, 8'h18);
    chk("add_ch", out_ch, 2);
    chk("add_ovf", overflow, 0);
    in_valid = 1'b0; peek_ch = 2'd2; #1;
    chk("peek2", peek_data, 8'h1D);
    tick();
    chk("drained_valid", out_valid, 0);

    // SUB borrow from zero
    drive(1'b1, OP_SUB, 2'd0, 8'h01); tick();
    $display("SUB ch0 0x01 -> out_ch %0d out_data 0x%0h ovf %0d", out_ch, out_data, overflow);
    chk("sub_data", out_data, SUB0_EXP);
    chk("sub_ch", out_ch, 0);
    chk("sub_ovf", overflow, 1);

    // Backpressure: result held, queued command waits, then drain+accept together
    out_ready = 1'b0;
    drive(1'b1, OP_LOAD, 2'd3, 8'h22); #1;
    chk("stall_in_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("stall cycle %0d -> out_valid %0d out_data 0x%0h in_ready %0d", i, out_valid, out_data, in_ready);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, SUB0_EXP);
      chk("stall_ch", out_ch, 0);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; #1;
    chk("drain_in_ready", in_ready, 1);
    tick();
    $display("LOAD ch3 0x22 (queued) -> out_ch %0d out_data 0x%0h", out_ch, out_data);
    chk("queued_valid", out_valid, 1);
    chk("queued_data", out_data, 8'h22);
    chk("queued_ch", out_ch, 3);

    // Make every channel nonzero, then CLEAR_ALL with overflow set
    drive(1'b1, OP_LOAD, 2'd0, 8'h07); tick();
    drive(1'b1, OP_LOAD, 2'd1, 8'h11); tick();
    chk("pre_clr_data", out_data, 8'h11);
    chk("pre_clr_ovf", overflow, 1);
    drive(1'b1, OP_CLEAR_ALL, 2'd0, 8'h00); tick();
    in_valid = 1'b0;
    chk("sweep_ovf_hold", overflow, 1);
    chk("sweep_out_valid", out_valid, 0);
    chk("sweep_in_ready_c0", in_ready, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("sweep_in_ready", in_ready, 0);
      chk("sweep_no_valid", out_valid, 0);
    end
    tick();
    $display("CLEAR_ALL -> out_ch %0d out_data 0x%0h ovf %0d", out_ch, out_data, overflow);
    chk("clr_valid", out_valid, 1);
    chk("clr_ch", out_ch, 3);
    chk("clr_data", out_data, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_in_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      peek_ch = 2'(c); #1;
      chk("clr_peek", peek_data, 8'h05);
    end
    tick();
    chk("clr_drained", out_valid, 0);

    // ADD with carry out
    drive(1'b1, OP_LOAD, 2'd1, 8'hFE); tick();
    chk("loadfe_data", out_data, 8'hFE);
    chk("loadfe_ovf", overflow, 0);
    drive(1'b1, OP_ADD, 2'd1, 8'h01); tick();
    in_valid = 1'b0;
    $display("ADD ch1 0x01 -> out_data 0x%0h ovf %0d", out_data, overflow);
    chk("addc_data", out_data, ADD1_EXP);
    chk("addc_ovf", overflow, 1);

    // Reset mid-sweep
    drive(1'b1, OP_CLEAR_ALL, 2'd0, 8'h00); tick();
    in_valid = 1'b0; peek_ch = 2'd1;
    tick();
    rst_n = 1'b0; #1;
    $display("reset mid-sweep -> out_valid %0d out_ch %0d out_data 0x%0h ovf %0d", out_valid, out_ch, out_data, overflow);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_out_ch", out_ch, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_peek1", peek_data, 8'h05);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_no_valid", out_valid, 0);
    end
    chk("post_rst_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
